write_reg_bank: RTL and testbench
=================================

// Module: write_reg_bank
// PURPOSE
//  Draws a parametrised bank of registers as text rows on the VGA framebuffer.
//  Each row reads "R<i>:<hex>", for example "R3:BEEF".
//  It sequences glyph requests to the per-character glyph writer (write_letter)
//  through a req/ack handshake. It sits between the register-file debug tap and
//  the VRAM glyph path.
//  It generalises the single-register writer to NUM_REGS rows and DATA_W-bit values.
//  It adds a changed-only redraw mode that skips rows whose value is unchanged.
// PARAMETERS
//  NUM_REGS  4   rows drawn, 1..16; the index prints as one hex digit
//  DATA_W    16  register width, a multiple of 4; prints DATA_W/4 hex digits
//  CHAR_W    7   horizontal pixel pitch between glyphs
//  ROW_H     10  vertical pixel pitch between rows
// PORTS
//  clk          in   1                 system clock; all logic is on its rising edge
//  rst          in   1                 reset, synchronous and active-high
//  start        in   1                 request a redraw; sampled only in IDLE
//  changed_only in   1                 sampled with start; 1 = draw only rows whose value changed
//  regs_flat    in   NUM_REGS*DATA_W   register values; reg i is at [i*DATA_W +: DATA_W]
//  base_x       in   10                pixel x of the first glyph of every row
//  base_y       in   9                 pixel y of row 0
//  busy         out  1                 high from the cycle after an accepted start until done
//  done         out  1                 one-cycle pulse when the pass completes
//  glyph_req    out  1                 glyph request valid
//  glyph_code   out  6                 character code: 0-9 = 0..9, A-F = 10..15, R = 27, ':' = 36
//  glyph_x      out  10                pixel x of the glyph
//  glyph_y      out  9                 pixel y of the glyph
//  glyph_ack    in   1                 one-cycle pulse from the glyph writer: glyph finished
// BEHAVIOUR
//  Reset: all outputs are 0. State = IDLE. All last-drawn valid bits are cleared.
//  States: IDLE -> LOAD -> SCAN -> REQ -> WAIT -> NEXT -> SCAN ... -> FIN -> IDLE.
//  IDLE: on start=1, go to LOAD.
//  LOAD: snapshot regs_flat, base_x, base_y and changed_only into shadow registers.
//   Set busy=1. Set row=0.
//   Inputs may change after this point without affecting the pass in progress.
//  SCAN: row is skipped when mode=changed_only, valid[row]=1 and shadow[row]==last[row].
//   A skipped row costs one cycle.
//   A row that is not skipped goes to REQ with char=0.
//   row==NUM_REGS goes to FIN.
//  REQ: drive glyph_req=1 with code, x and y. Go to WAIT the same cycle.
//  WAIT: glyph_req, glyph_code, glyph_x and glyph_y stay stable until glyph_ack.
//   glyph_req drops in the cycle after the ack.
//   glyph_ack outside WAIT is ignored.
//  Characters per row: CPR = 3 + DATA_W/4.
//   char 0 = 'R'
//   char 1 = row index as a hex digit
//   char 2 = ':'
//   chars 3.. = value nibbles, most-significant nibble first
//  glyph_x = base_x + char*CHAR_W, truncated to 10 bits (wraps mod 1024).
//  glyph_y = base_y + row*ROW_H, truncated to 9 bits (wraps mod 512).
//  NEXT: after the last char of a row, set last[row]=shadow[row], valid[row]=1 and row+1.
//   Otherwise char+1, then REQ.
//  Minimum throughput: REQ-to-REQ is 3 cycles when the ack returns the cycle after req.
//  FIN: done=1 for one cycle, busy=0, state -> IDLE. A start in that same cycle is ignored.
//  start while busy=1 is ignored and is not queued.
//  changed_only with all rows unchanged:
//   no glyph_req is issued
//   done is asserted NUM_REGS+2 cycles after the start cycle
//  rst mid-pass: the pass is abandoned.
//   glyph_req, busy and done are 0 the next cycle.
//   valid[] is cleared, so the next pass redraws every row.
//  Rows not fully drawn before an abort keep valid=0.
// TESTING
//  T1 NUM_REGS=4, DATA_W=16, regs={1234,BEEF,0000,FFFF}, base=(100,50), ack 1 cycle after req
//     -> 28 reqs.
//     First req: code 27 at (100,50).
//     Row 1 value digits: 11,14,14,15 at x=121,128,135,142, y=60.
//     done after the 28th ack.
//  T2 rerun T1 with changed_only=1 and only reg2 changed to 00A0
//     -> exactly 7 reqs, all at y=70, digits 0,0,10,0.
//  T3 changed_only=1 with no change -> zero reqs; done 6 cycles after start.
//  T4 ack delayed 20 cycles -> req, code, x and y stable for all 20 cycles.
//     A spurious start while busy has no effect.
//  T5 rst during row 2 -> outputs 0 the next cycle.
//     The following changed_only pass redraws all 4 rows (28 reqs).
//  T6 base_x=1020 -> char 1 glyph_x = 3 (wrap); base_y=505, row 1 -> glyph_y = 3.

Source files
------------

// File: rtl/write_reg_bank_if.sv
// Glyph request channel between the register-bank text renderer and the glyph writer.
// Latency: none, plain wires; the master holds a request until the slave pulses ack.
// Backpressure: the slave stalls the master by withholding glyph_ack.
// Ports: glyph_req/code/x/y driven by master, glyph_ack driven by slave.
interface write_reg_bank_if;
    logic       glyph_req;
    logic [5:0] glyph_code;
    logic [9:0] glyph_x;
    logic [8:0] glyph_y;
    logic       glyph_ack;

    modport master (
        output glyph_req,
        output glyph_code,
        output glyph_x,
        output glyph_y,
        input  glyph_ack
    );

    modport slave (
        input  glyph_req,
        input  glyph_code,
        input  glyph_x,
        input  glyph_y,
        output glyph_ack
    );
endinterface

// File: rtl/write_reg_bank.sv
// Renders NUM_REGS register values as "R<i>:<hex>" text rows through the glyph request channel.
// Latency: start -> LOAD next cycle; REQ-to-REQ 3 cycles at best; an all-skipped pass ends NUM_REGS+2 cycles after start.
// Backpressure: each glyph is held on gif until glyph_ack; start is only sampled in IDLE and never queued.
// Ports: clk, rst (sync, active-high), start, changed_only, regs_flat, base_x, base_y,
//        busy, done, gif (master side of write_reg_bank_if).
module write_reg_bank #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    parameter int CHAR_W   = 7,
    parameter int ROW_H    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       changed_only,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [9:0]                 base_x,
    input  logic [8:0]                 base_y,
    output logic                       busy,
    output logic                       done,
    write_reg_bank_if.master           gif
);

    localparam int CPR = 3 + DATA_W / 4;
    localparam int RW  = $clog2(NUM_REGS + 1);
    localparam int CW  = $clog2(CPR + 1);

    localparam logic [5:0] CODE_R     = 6'd27;
    localparam logic [5:0] CODE_COLON = 6'd36;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_REQ,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t                     state_q, state_d;
    logic [RW-1:0]              row_q, row_d;
    logic [CW-1:0]              char_q, char_d;
    logic [NUM_REGS*DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_REGS*DATA_W-1:0] last_q, last_d;
    logic [NUM_REGS-1:0]        valid_q, valid_d;
    logic                       mode_q, mode_d;
    logic [9:0]                 bx_q, bx_d;
    logic [8:0]                 by_q, by_d;

    // row_q reaches NUM_REGS only transiently; clamp so part-selects stay in range.
    logic [RW-1:0]     row_sel;
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] last_val;
    logic              skip_row;
    logic              last_row;
    logic              last_char;
    logic [CW-1:0]     nib_idx;
    logic [3:0]        nibble;
    logic [5:0]        code;
    logic              req;

    always_comb begin
        row_sel   = (row_q < RW'(NUM_REGS)) ? row_q : '0;
        cur_val   = shadow_q[row_sel*DATA_W +: DATA_W];
        last_val  = last_q[row_sel*DATA_W +: DATA_W];
        skip_row  = mode_q && valid_q[row_sel] && (cur_val == last_val);
        last_row  = (row_q == RW'(NUM_REGS - 1));
        last_char = (char_q == CW'(CPR - 1));
        // Character 3 maps to the most significant nibble, the last character to nibble 0.
        nib_idx   = CW'(CPR - 1) - char_q;
        nibble    = 4'(cur_val >> {nib_idx, 2'b00});
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        char_d   = char_q;
        shadow_d = shadow_q;
        last_d   = last_q;
        valid_d  = valid_q;
        mode_d   = mode_q;
        bx_d     = bx_q;
        by_d     = by_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shadow_d = regs_flat;
                bx_d     = base_x;
                by_d     = base_y;
                mode_d   = changed_only;
                row_d    = '0;
                state_d  = S_SCAN;
            end
            S_SCAN: begin
                if (row_q >= RW'(NUM_REGS)) begin
                    state_d = S_FIN;
                end else if (skip_row) begin
                    // Skipping the final row jumps straight to FIN so an idle pass
                    // costs exactly one cycle per row.
                    row_d   = row_q + 1'b1;
                    state_d = last_row ? S_FIN : S_SCAN;
                end else begin
                    char_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gif.glyph_ack) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_char) begin
                    // Only a fully drawn row is remembered as drawn.
                    last_d[row_sel*DATA_W +: DATA_W] = cur_val;
                    valid_d[row_sel]                 = 1'b1;
                    row_d                            = row_q + 1'b1;
                    state_d                          = last_row ? S_FIN : S_SCAN;
                end else begin
                    char_d  = char_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            char_q   <= '0;
            shadow_q <= '0;
            last_q   <= '0;
            valid_q  <= '0;
            mode_q   <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            char_q   <= char_d;
            shadow_q <= shadow_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            mode_q   <= mode_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
        end
    end

    always_comb begin
        case (char_q)
            CW'(0):  code = CODE_R;
            CW'(1):  code = 6'(row_sel);
            CW'(2):  code = CODE_COLON;
            default: code = {2'b00, nibble};
        endcase
    end

    // Outputs decode straight from registered state, so they are 0 out of reset
    // and hold steady for the whole WAIT period.
    assign req            = (state_q == S_REQ) || (state_q == S_WAIT);
    assign busy           = (state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_REQ) ||
                            (state_q == S_WAIT) || (state_q == S_NEXT);
    assign done           = (state_q == S_FIN);
    assign gif.glyph_req  = req;
    assign gif.glyph_code = req ? code : 6'd0;
    assign gif.glyph_x    = req ? (bx_q + 10'(int'(char_q) * CHAR_W)) : 10'd0;
    assign gif.glyph_y    = req ? (by_q + 9'(int'(row_sel) * ROW_H)) : 9'd0;

endmodule

// File: tb/tb_write_reg_bank.sv
// Scoreboard bench for write_reg_bank: expected glyphs are queued per pass, a monitor pops on each new request.
// Latency: ack returns a programmable number of cycles after a request is first seen.
// Backpressure: the responder withholds glyph_ack for ack_delay cycles.
module tb_write_reg_bank;

    typedef struct packed {
        logic [5:0] c;
        logic [9:0] x;
        logic [8:0] y;
    } g_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        changed_only;
    logic [63:0] regs_flat;
    logic [9:0]  base_x;
    logic [8:0]  base_y;
    logic        busy;
    logic        done;

    write_reg_bank_if gif ();

    write_reg_bank dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .changed_only (changed_only),
        .regs_flat    (regs_flat),
        .base_x       (base_x),
        .base_y       (base_y),
        .busy         (busy),
        .done         (done),
        .gif          (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    g_t exp_q[$];
    g_t log_q[$];
    int n_cmp     = 0;
    int n_bad     = 0;
    int ack_delay = 1;
    bit stab_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected glyphs of one row, built from the textual row format.
    task automatic push_row(input int r, input logic [15:0] v, input logic [9:0] bx, input logic [8:0] by);
        g_t g;
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      g.c = 6'd27;
            else if (c == 1) g.c = 6'(r);
            else if (c == 2) g.c = 6'd36;
            else             g.c = 6'((v >> (4 * (6 - c))) & 16'hF);
            g.x = 10'(int'(bx) + c * 7);
            g.y = 9'(int'(by) + r * 10);
            exp_q.push_back(g);
        end
    endtask

    task automatic push_all(input logic [63:0] rv, input logic [9:0] bx, input logic [8:0] by);
        for (int r = 0; r < 4; r++) push_row(r, rv[r*16 +: 16], bx, by);
    endtask

    task automatic run_pass(input string nm, input bit co, input logic [63:0] rv,
                            input logic [9:0] bx, input logic [8:0] by, output int cyc);
        @(negedge clk);
        changed_only = co;
        regs_flat    = rv;
        base_x       = bx;
        base_y       = by;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk({nm, "_done_timeout"}, 0, 1);
        chk({nm, "_exp_left"}, exp_q.size(), 0);
    endtask

    // Responder: ack pulses ack_delay cycles after the request is first seen.
    initial begin
        int wcnt;
        wcnt          = 0;
        gif.glyph_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (gif.glyph_req) begin
                if (wcnt == ack_delay) begin
                    gif.glyph_ack = 1'b1;
                    @(negedge clk);
                    gif.glyph_ack = 1'b0;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: a rising glyph_req is a new glyph; a held request must not move.
    initial begin
        logic prev_req;
        g_t   cur, held, e;
        prev_req = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            cur = '{c: gif.glyph_code, x: gif.glyph_x, y: gif.glyph_y};
            if (gif.glyph_req && !prev_req) begin
                log_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("glyph_code", 32'(cur.c), 32'(e.c));
                    chk("glyph_x", 32'(cur.x), 32'(e.x));
                    chk("glyph_y", 32'(cur.y), 32'(e.y));
                end
                held = cur;
            end else if (gif.glyph_req && stab_en) begin
                chk("held_glyph", 32'(cur), 32'(held));
            end
            prev_req = gif.glyph_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] RV1 = 64'hFFFF_0000_BEEF_1234;
    localparam logic [63:0] RV2 = 64'hFFFF_00A0_BEEF_1234;

    initial begin
        int b, cyc, waited;
        int d1[4];
        int x1[4];
        int d2[4];
        d1 = '{11, 14, 14, 15};
        x1 = '{121, 128, 135, 142};
        d2 = '{0, 0, 10, 0};

        rst          = 1'b1;
        start        = 1'b0;
        changed_only = 1'b0;
        regs_flat    = '0;
        base_x       = '0;
        base_y       = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", gif.glyph_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_code", gif.glyph_code, 0);
        chk("rst_x", gif.glyph_x, 0);
        chk("rst_y", gif.glyph_y, 0);
        rst = 1'b0;

        // T1: full draw.
        b = log_q.size();
        push_all(RV1, 10'd100, 9'd50);
        run_pass("t1", 1'b0, RV1, 10'd100, 9'd50, cyc);
        chk("t1_nreq", log_q.size() - b, 28);
        chk("t1_first_code", log_q[b].c, 27);
        chk("t1_first_x", log_q[b].x, 100);
        chk("t1_first_y", log_q[b].y, 50);
        for (int i = 0; i < 4; i++) begin
            chk("t1_row1_digit", log_q[b+10+i].c, d1[i]);
            chk("t1_row1_x", log_q[b+10+i].x, x1[i]);
            chk("t1_row1_y", log_q[b+10+i].y, 60);
        end

        // T2: only reg2 changed.
        b = log_q.size();
        push_row(2, 16'h00A0, 10'd100, 9'd50);
        run_pass("t2", 1'b1, RV2, 10'd100, 9'd50, cyc);
        chk("t2_nreq", log_q.size() - b, 7);
        for (int i = 0; i < 7; i++) chk("t2_y", log_q[b+i].y, 70);
        for (int i = 0; i < 4; i++) chk("t2_digit", log_q[b+3+i].c, d2[i]);

        // T3: nothing changed.
        b = log_q.size();
        run_pass("t3", 1'b1, RV2, 10'd100, 9'd50, cyc);
        chk("t3_nreq", log_q.size() - b, 0);
        chk("t3_done_cycle", cyc, 6);

        // T4: slow ack with a spurious start and input change mid-pass.
        ack_delay = 20;
        stab_en   = 1'b1;
        b = log_q.size();
        push_all(RV2, 10'd100, 9'd50);
        fork
            run_pass("t4", 1'b0, RV2, 10'd100, 9'd50, cyc);
            begin
                repeat (30) @(negedge clk);
                start     = 1'b1;
                regs_flat = 64'h1111_2222_3333_4444;
                base_x    = 10'd7;
                @(negedge clk);
                start = 1'b0;
            end
        join
        chk("t4_nreq", log_q.size() - b, 28);
        repeat (5) @(negedge clk);
        chk("t4_busy_after", busy, 0);
        chk("t4_no_extra", log_q.size() - b, 28);
        stab_en   = 1'b0;
        ack_delay = 1;

        // T5: reset during row 2, then a changed_only pass redraws everything.
        b = log_q.size();
        push_all(RV2, 10'd100, 9'd50);
        @(negedge clk);
        changed_only = 1'b0;
        regs_flat    = RV2;
        base_x       = 10'd100;
        base_y       = 9'd50;
        start        = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (log_q.size() < b + 15 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("t5_reach_row2", (log_q.size() >= b + 15) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_req", gif.glyph_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        b = log_q.size();
        push_all(RV2, 10'd100, 9'd50);
        run_pass("t5", 1'b1, RV2, 10'd100, 9'd50, cyc);
        chk("t5_nreq", log_q.size() - b, 28);

        // T6: coordinate wrap.
        b = log_q.size();
        push_all(RV1, 10'd1020, 9'd505);
        run_pass("t6", 1'b0, RV1, 10'd1020, 9'd505, cyc);
        chk("t6_nreq", log_q.size() - b, 28);
        chk("t6_x0", log_q[b].x, 1020);
        chk("t6_x_wrap", log_q[b+1].x, 3);
        chk("t6_y_wrap", log_q[b+7].y, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
